// File: rtl/addsub_pkg.sv
// Shared types for the two-stage add/subtract pipeline: operation encoding
// and the control half of the first-stage payload.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD     = 2'b00,
        SUB     = 2'b01,
        ABSDIFF = 2'b10,
        RSUB    = 2'b11
    } mode_e;

    // Operands travel beside this struct because their width follows the
    // pipeline's N parameter.
    typedef struct packed {
        mode_e mode;
        logic  cin;
        logic  aGtB;
        logic  aLtB;
    } s1_ctrl_t;

endpackage

// File: rtl/carry_chain.sv
// N-bit ripple-carry adder built from full-adder cells; used by the second
// stage of addsub_pipe.
module carry_chain #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[N];

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add / sub / absdiff / reverse-sub pipeline.
// Define ADDSUB_PIPE_SAT_EN to saturate ADD overflow and SUB/RSUB underflow.
module addsub_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         a_gt_b
);

    import addsub_pkg::*;

    logic         r_s1Valid;
    logic [N-1:0] r_s1A;
    logic [N-1:0] r_s1B;
    s1_ctrl_t     r_s1Ctrl;

    logic         r_s2Valid;
    logic [N-1:0] r_result;
    logic         r_cout;
    logic         r_zero;
    logic         r_aGtB;

    logic         w_s2Load;
    logic         w_s1Load;
    logic         w_accept;
    logic [N-1:0] w_opX;
    logic [N-1:0] w_opY;
    logic         w_opCin;
    logic [N-1:0] w_sum;
    logic         w_carry;
    logic [N-1:0] w_final;
    logic         w_flag;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2Load = !r_s2Valid || out_ready;
    assign w_s1Load = !r_s1Valid || w_s2Load;
    assign w_accept = in_valid && w_s1Load;
    assign in_ready = w_s1Load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1Ctrl  <= '0;
        end else if (w_s1Load) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1A         <= a;
                r_s1B         <= b;
                r_s1Ctrl.mode <= mode_e'(mode);
                r_s1Ctrl.cin  <= cin;
                r_s1Ctrl.aGtB <= (a > b);
                r_s1Ctrl.aLtB <= (a < b);
            end
        end
    end

    // Subtraction is add-the-complement; for ABSDIFF the smaller operand is
    // the one complemented, so a==b falls through to 0.
    always_comb begin
        w_opX   = r_s1A;
        w_opY   = r_s1B;
        w_opCin = r_s1Ctrl.cin;
        case (r_s1Ctrl.mode)
            SUB: begin
                w_opY   = ~r_s1B;
                w_opCin = !r_s1Ctrl.cin;
            end
            RSUB: begin
                w_opX   = r_s1B;
                w_opY   = ~r_s1A;
                w_opCin = !r_s1Ctrl.cin;
            end
            ABSDIFF: begin
                w_opCin = 1'b1;
                if (r_s1Ctrl.aLtB) begin
                    w_opX = r_s1B;
                    w_opY = ~r_s1A;
                end else begin
                    w_opX = r_s1A;
                    w_opY = ~r_s1B;
                end
            end
            default: ;
        endcase
    end

    carry_chain #(.N(N)) u_chain (
        .i_a    (w_opX),
        .i_b    (w_opY),
        .i_cin  (w_opCin),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    always_comb begin
        w_final = w_sum;
        w_flag  = 1'b0;
        case (r_s1Ctrl.mode)
            ADD:       w_flag = w_carry;
            SUB, RSUB: w_flag = !w_carry;
            default:   w_flag = 1'b0;
        endcase
`ifdef ADDSUB_PIPE_SAT_EN
        if (r_s1Ctrl.mode == ADD && w_carry) begin
            w_final = '1;
        end else if ((r_s1Ctrl.mode == SUB || r_s1Ctrl.mode == RSUB) && !w_carry) begin
            w_final = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_aGtB    <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_result <= w_final;
                r_cout   <= w_flag;
                r_zero   <= (w_final == '0);
                r_aGtB   <= r_s1Ctrl.aGtB;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign a_gt_b    = r_aGtB;

endmodule
